// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring-divide step per cycle.
// Optional build macro MULT_DIV_FAST_MUL_EN selects a single-cycle multiplier for MULT/MULTU.
module mult_div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] DONE_ST = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        sign_q;
  logic        sign_r;
  logic        div_zero;
  logic [31:0] a_orig;
  logic [31:0] operand;
  logic [31:0] work_hi;
  logic [31:0] work_lo;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  logic        signed_op;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  always_comb begin
    signed_op = ~op[0];
    abs_a     = (signed_op && a[31]) ? (32'd0 - a) : a;
    abs_b     = (signed_op && b[31]) ? (32'd0 - b) : b;
  end

  // Multiply step: work_hi:work_lo holds partial product above the remaining multiplier bits.
  logic [32:0] mul_sum;
  logic [31:0] mul_hi;
  logic [31:0] mul_lo;

  always_comb begin
    mul_sum = {1'b0, work_hi} + {1'b0, operand};
    if (work_lo[0]) begin
      mul_hi = mul_sum[32:1];
      mul_lo = {mul_sum[0], work_lo[31:1]};
    end else begin
      mul_hi = {1'b0, work_hi[31:1]};
      mul_lo = {work_hi[0], work_lo[31:1]};
    end
  end

  // Restoring divide step: work_hi is the partial remainder, work_lo shifts dividend out / quotient in.
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [31:0] div_hi;
  logic [31:0] div_lo;

  always_comb begin
    div_shift = {work_hi, work_lo[31]};
    div_ge    = (div_shift >= {1'b0, operand});
    div_diff  = div_shift[31:0] - operand;
    div_hi    = div_ge ? div_diff : div_shift[31:0];
    div_lo    = {work_lo[30:0], div_ge};
  end

  logic [63:0] mul_mag;
  logic [63:0] mul_res;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_comb begin
    mul_mag = {mul_hi, mul_lo};
    mul_res = sign_q ? (64'd0 - mul_mag) : mul_mag;
    if (!is_div) begin
      res_hi = mul_res[63:32];
      res_lo = mul_res[31:0];
    end else if (div_zero) begin
      res_hi = a_orig;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = sign_r ? (32'd0 - div_hi) : div_hi;
      res_lo = sign_q ? (32'd0 - div_lo) : div_lo;
    end
  end

`ifdef MULT_DIV_FAST_MUL_EN
  logic [63:0] fast_prod;
  logic [63:0] fast_a;
  logic [63:0] fast_b;

  always_comb begin
    fast_a    = op[0] ? {32'd0, a} : {{32{a[31]}}, a};
    fast_b    = op[0] ? {32'd0, b} : {{32{b[31]}}, b};
    fast_prod = fast_a * fast_b;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      is_div   <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      a_orig   <= 32'd0;
      operand  <= 32'd0;
      work_hi  <= 32'd0;
      work_lo  <= 32'd0;
      hi_reg   <= 32'd0;
      lo_reg   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
`ifdef MULT_DIV_FAST_MUL_EN
            if (!op[1]) begin
              hi_reg <= fast_prod[63:32];
              lo_reg <= fast_prod[31:0];
              state  <= DONE_ST;
            end else begin
              state  <= RUN;
            end
`else
            state    <= RUN;
`endif
            cnt      <= 5'd0;
            is_div   <= op[1];
            sign_q   <= signed_op & (a[31] ^ b[31]);
            sign_r   <= signed_op & a[31];
            div_zero <= op[1] & (b == 32'd0);
            a_orig   <= a;
            operand  <= op[1] ? abs_b : abs_a;
            work_hi  <= 32'd0;
            work_lo  <= op[1] ? abs_a : abs_b;
          end
        end
        RUN: begin
          work_hi <= is_div ? div_hi : mul_hi;
          work_lo <= is_div ? div_lo : mul_lo;
          cnt     <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            hi_reg <= res_hi;
            lo_reg <= res_lo;
            state  <= DONE_ST;
          end
        end
        DONE_ST: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE_ST);
  assign hi_out = hi_reg;
  assign lo_out = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases plus random operands against a longint reference model.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'd0;
  logic [31:0] a     = 32'd0;
  logic [31:0] b     = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int passed = 0;
  int total  = 0;

  mult_div_unit dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi_out(hi_out),
    .lo_out(lo_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  // Reference: plain integer arithmetic on the architectural definition.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p, q, r;
    logic [63:0] up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: begin p = sx * sy; return p; end
      2'd1: begin up = {32'd0, x} * {32'd0, y}; return up; end
      2'd2: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o);
`ifdef MULT_DIV_FAST_MUL_EN
    if (!o[1]) return 0;
`endif
    return 32;
  endfunction

  // Issue one op, optionally poke an ignored start mid-run, then check latency, result and release.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int poke_at);
    logic [63:0] exp;
    int lat;
    exp = model(o, x, y);
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clock);
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    check({tag, ".busy0"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 100) begin
      if (lat == poke_at) begin
        start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd4;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      lat++;
    end
    start = 1'b0;
    check({tag, ".lat"}, lat, exp_lat(o));
    check({tag, ".hi"}, hi_out, exp[63:32]);
    check({tag, ".lo"}, lo_out, exp[31:0]);
    @(negedge clock);
    check({tag, ".done_drop"}, {31'd0, done}, 32'd0);
    check({tag, ".busy_drop"}, {31'd0, busy}, 32'd0);
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", o, x, y, hi_out, lo_out, lat);
  endtask

  initial begin
    logic [63:0] held;
    logic [31:0] sp [6];
    int saw_done;
    sp = '{32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd7};

    reset = 1'b1;
    #12;
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.done", {31'd0, done}, 32'd0);
    check("reset.hi", hi_out, 32'd0);
    check("reset.lo", lo_out, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check("multu_max.hi_const", hi_out, 32'hFFFF_FFFE);
    run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd5, -1);
    check("mult_neg.lo_const", lo_out, 32'hFFFF_FFF1);
    run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, -1);
    check("div_neg.lo_const", lo_out, 32'hFFFF_FFFD);
    run_op("divu", 2'd3, 32'd100, 32'd7, -1);
    run_op("divu_zero", 2'd3, 32'h1234, 32'd0, -1);
    check("divu_zero.hi_const", hi_out, 32'h0000_1234);
    run_op("div_zero_neg", 2'd2, 32'hFFFF_FF00, 32'd0, -1);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("div_ovf.lo_const", lo_out, 32'h8000_0000);
    run_op("mult_min", 2'd0, 32'h8000_0000, 32'h8000_0000, -1);
    run_op("div_rem_neg", 2'd2, 32'd7, 32'hFFFF_FFFE, -1);

    run_op("ignored_start", 2'd3, 32'd100, 32'd7, 4);
    check("ignored_start.lo_const", lo_out, 32'd14);
    check("ignored_start.hi_const", hi_out, 32'd2);

    held = {hi_out, lo_out};
    repeat (5) @(negedge clock);
    check("hold.hi", hi_out, held[63:32]);
    check("hold.lo", lo_out, held[31:0]);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] x, y;
      x = (i % 3 == 0) ? sp[$urandom_range(0, 5)] : $urandom;
      y = (i % 4 == 1) ? sp[$urandom_range(0, 5)] : $urandom;
      if (i % 5 == 2) y = y >> $urandom_range(0, 31);
      run_op($sformatf("rand%0d", i), 2'(i % 4), x, y, -1);
    end

    // Reset in the middle of a divide: results clear and the op is abandoned.
    @(negedge clock);
    start = 1'b1; op = 2'd3; a = 32'd1000; b = 32'd3;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    check("midreset.busy", {31'd0, busy}, 32'd0);
    check("midreset.hi", hi_out, 32'd0);
    check("midreset.lo", lo_out, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    saw_done = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) saw_done++;
    end
    check("midreset.no_done", saw_done, 32'd0);
    check("midreset.lo_hold", lo_out, 32'd0);
    $display("midreset busy=%0d hi=%h lo=%h", busy, hi_out, lo_out);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
